// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scan driver: one digit lit per slot, prescaled from clk,
// with guard blanking, PWM dimming, leading-zero suppression and per-frame input snapshot.
module seg7_scan #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     enable,
    output logic                  frame_start
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]       p;
    logic [IW-1:0]       i;
    logic [BRIGHT_W-1:0] q;

    logic [4*DIGITS-1:0] snap_digits;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lz;

    logic [DIGITS-1:0]   dark;
    logic                zero_run;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_dark;
    logic                pwm_on;
    logic                lit;
    logic                frame_edge;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Zero run walks down from the leftmost digit; digit 0 always shows so "0" stays visible.
    always_comb begin
        dark     = snap_blank;
        zero_run = snap_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (zero_run && (snap_digits[4*k +: 4] == 4'h0)) begin
                dark[k] = 1'b1;
            end else begin
                zero_run = 1'b0;
            end
        end
    end

    always_comb begin
        cur_code = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == i) begin
                cur_code = snap_digits[4*k +: 4];
                cur_dp   = snap_dp[k];
                cur_dark = dark[k];
            end
        end
    end

    assign pwm_on     = (brightness == {BRIGHT_W{1'b1}}) || (q < brightness);
    assign lit        = (p >= P_GUARD) && pwm_on && !cur_dark;
    assign frame_edge = (p == '0) && (i == I_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            p           <= '0;
            i           <= I_LAST;
            q           <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            segment     <= 8'hFF;
            enable      <= '1;
            frame_start <= 1'b0;
        end else begin
            q <= q + BRIGHT_W'(1);

            if (p == P_LAST) begin
                p <= '0;
                i <= (i == '0) ? I_LAST : i - IW'(1);
            end else begin
                p <= p + PW'(1);
            end

            frame_start <= frame_edge;
            if (frame_edge) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blank  <= blank;
                snap_lz     <= lz_suppress;
            end

            if (lit) begin
                segment <= ~{hex7(cur_code), cur_dp};
                enable  <= ~(DIGITS'(1) << i);
            end else begin
                segment <= 8'hFF;
                enable  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with DIGITS=4, SCAN_DIV=8, GUARD=2, BRIGHT_W=2: per-cycle
// expectations pushed to a scoreboard from a table of display patterns.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  brightness = '0;
    logic [7:0]  segment;
    logic [3:0]  enable;
    logic        frame_start;

    seg7_scan #(.DIGITS(4), .SCAN_DIV(8), .GUARD(2), .BRIGHT_W(2)) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
        .lz_suppress(lz_suppress), .brightness(brightness),
        .segment(segment), .enable(enable), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // seg holds the expected pattern of slots 3..2..1..0; 8'hFF marks a dark digit
    typedef struct packed {
        logic [15:0] dg;
        logic [3:0]  dpv;
        logic [3:0]  bl;
        logic        lz;
        logic [1:0]  br;
        logic [31:0] seg;
    } vec_t;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] en;
        logic       fs;
    } exp_t;

    vec_t        tbl [9];
    exp_t        sb [$];
    vec_t        cur;
    logic [31:0] shown;
    int          cyc, tick, last_fs, total, bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at tick %0d", name, act, req, tick);
        end
    endtask

    task automatic drive(input vec_t v);
        cur         = v;
        digits      = v.dg;
        dp          = v.dpv;
        blank       = v.bl;
        lz_suppress = v.lz;
        brightness  = v.br;
    endtask

    task automatic step(input logic r);
        exp_t       e;
        int         p, s, q;
        logic [7:0] sg;
        logic       lit;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("segment", segment, e.seg);
            check("enable", enable, e.en);
            check("frame_start", frame_start, e.fs);
        end
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("frame_period", tick - last_fs, 32);
            last_fs = tick;
        end
        rst = r;
        if (r) begin
            sb.push_back({8'hFF, 4'hF, 1'b0});
        end else begin
            p   = cyc % 8;
            s   = 3 - (cyc / 8) % 4;
            q   = cyc % 4;
            sg  = shown[8*s +: 8];
            lit = (p >= 2) && (cur.br == 2'd3 || q < int'(cur.br)) && (sg != 8'hFF);
            sb.push_back({lit ? sg : 8'hFF, lit ? ~(4'b0001 << s) : 4'hF, (cyc % 32) == 0});
            if (cyc % 32 == 0) shown = cur.seg;
        end
        @(posedge clk);
        #1;
        tick++;
        if (r) begin
            cyc     = 0;
            shown   = {4{8'h03}};
            last_fs = -1;
        end else begin
            cyc++;
        end
    endtask

    initial begin
        tbl[0] = {16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3, 32'h9F250D99};
        tbl[1] = {16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hFFFF4903};
        tbl[2] = {16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hFFFFFF03};
        tbl[3] = {16'h8888, 4'b0001, 4'b0100, 1'b0, 2'd3, 32'h01FF0100};
        tbl[4] = {16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1, 32'h9F250D99};
        tbl[5] = {16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h9F250D99};
        tbl[6] = {16'hABCD, 4'b1010, 4'b0000, 1'b1, 2'd3, 32'h10C16285};
        tbl[7] = {16'h0E0F, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hFF610371};
        tbl[8] = {16'h9670, 4'b0000, 4'b0000, 1'b1, 2'd2, 32'h09411F03};

        total   = 0;
        bad     = 0;
        tick    = 0;
        cyc     = 0;
        last_fs = -1;
        shown   = {4{8'h03}};
        cur     = '0;

        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({8'hFF, 4'hF, 1'b0});
        step(1'b1);
        step(1'b1);

        // New inputs land mid-frame (slot 2); the model only adopts them at the snapshot.
        drive(tbl[0]);
        for (int e = 1; e < 9; e++) begin
            repeat (12) step(1'b0);
            drive(tbl[e]);
            repeat (20) step(1'b0);
        end
        repeat (33) step(1'b0);

        // Reset in the middle of slot 1, then the scan must resume at slot 3.
        drive(tbl[0]);
        while (cyc % 32 != 20) step(1'b0);
        step(1'b1);
        repeat (3) step(1'b0);
        check("restart_enable", enable, 4'b0111);
        check("restart_segment", segment, 8'h9F);
        repeat (40) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
